// File: rtl/moore_seq_det_param.sv
// rtl/moore_seq_det_param.sv - parametrised Moore serial pattern detector with saturating match counter
module moore_seq_det_param #(
   parameter int                     PATTERN_LEN = 4,
   parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1100,
   parameter int                     COUNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               ip,
   input  logic               overlap,
   input  logic               clr,
   output logic               op,
   output logic [COUNT_W-1:0] match_cnt,
   output logic [5:0]         fill
);

   localparam logic [5:0]         FILL_FULL = 6'(PATTERN_LEN);
   localparam logic [COUNT_W-1:0] CNT_MAX   = {COUNT_W{1'b1}};

   logic [PATTERN_LEN-1:0] hist;
   logic [PATTERN_LEN-1:0] hist_n;
   logic [5:0]             fill_n;
   logic                   hit;
   logic                   m;

   // fill gates the compare so stale or reset-zero history never matches early
   always_comb begin
      hist_n = {hist[PATTERN_LEN-2:0], ip};
      fill_n = (fill == FILL_FULL) ? FILL_FULL : fill + 6'd1;
      hit    = en && (fill_n == FILL_FULL) && (hist_n == PATTERN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hist      <= '0;
         fill      <= '0;
         m         <= 1'b0;
         match_cnt <= '0;
      end else begin
         if (en) begin
            hist <= hist_n;
            m    <= hit;
            // non-overlap restarts the window; hist is left alone, fill masks it
            fill <= (hit && !overlap) ? 6'd0 : fill_n;
         end
         if (clr)
            match_cnt <= '0;
         else if (hit && (match_cnt != CNT_MAX))
            match_cnt <= match_cnt + COUNT_W'(1);
      end
   end

   assign op = m;

endmodule

// File: doc/moore_seq_det_param.md
Name: moore_seq_det_param

Overview:
- Parametrised Moore-style serial pattern detector, the successor to the fixed 1100 Moore detector.
- Detects an arbitrary PATTERN_LEN-bit pattern, MSB received first, on a 1-bit serial input qualified by a sample enable.
- Overlap vs non-overlap detection is selectable at run time.
- Keeps a saturating match counter.
- Sits after the serial front-end; op feeds downstream framing/alarm logic.

Parameters:
- PATTERN_LEN, 4, pattern length in bits; legal range 2..32.
- PATTERN, 4'b1100, pattern value [PATTERN_LEN-1:0]; bit PATTERN_LEN-1 is the first bit received.
- COUNT_W, 8, width of the match counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; ip is consumed only on edges where en=1.
- ip  input  1  serial data bit.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- clr  input  1  synchronous clear of match_cnt only.
- op  output  1  Moore detect output, decoded from registered state.
- match_cnt  output  COUNT_W  number of matches since reset/clr; saturating.
- fill  output  6  number of valid history bits, 0..PATTERN_LEN (debug/status).

Behaviour:
- Reset (reset=1 at an edge): hist=0, fill=0, op=0, match_cnt=0. Reset overrides en, clr and all other inputs. Reset asserted mid-sequence discards all partial history.
- State is the history register hist[PATTERN_LEN-1:0], the fill count, and the match flag m.
- Edge with en=1:
  - hist_n = {hist[PATTERN_LEN-2:0], ip}
  - fill_n = min(fill+1, PATTERN_LEN)
  - hit = (fill_n == PATTERN_LEN) && (hist_n == PATTERN)
  - Registers: hist <= hist_n; m <= hit.
  - fill <= hit && !overlap ? 0 : fill_n.
- Edge with en=0: hist, fill and m all hold.
- op = m (Moore output):
  - Rises in the cycle after the edge that sampled the final pattern bit.
  - Stays high until the next enabled edge.
  - With en held high, op is a 1-cycle pulse per match.
- Non-overlap mode: after a hit, the next match needs PATTERN_LEN fresh bits. hist is not cleared, but fill=0 masks it.
- Overlap mode: the pattern suffix may begin the next match.
- overlap is sampled on each enabled edge; a mid-stream change affects only the hit evaluated on that edge.
- match_cnt:
  - Increments by 1 on each edge where hit=1 (requires en=1).
  - Saturates at 2^COUNT_W-1 (no wrap).
  - clr=1 sets match_cnt=0. If clr and hit occur on the same edge, clr wins: match_cnt=0.
  - clr does not affect hist, fill or op.
- The first PATTERN_LEN-1 enabled bits after reset can never produce a hit (fill gating), even if the pattern is all zeros.
- Latency: exactly 1 clk from the final pattern-bit edge to op=1.

Test Plan:
- PATTERN=4'b1100, overlap=0, en=1:
  - Stimulus: reset for 1 cycle, then ip = 0,1,1,0,0,1,0,0,1,1,0,1,1,0,0,0,1,0,0,1,0,1 at one bit per clk.
  - Response: op pulses exactly twice, in the cycles after bits 5 and 15.
  - Final match_cnt=2.
  - Repeat with overlap=1: identical result, since 1100 cannot self-overlap.
- PATTERN=4'b1010, stream 1,0,1,0,1,0, en=1:
  - overlap=1: op pulses after bits 4 and 6, match_cnt=2.
  - overlap=0: op pulses after bit 4 only, match_cnt=1.
- en gating, PATTERN=4'b1100:
  - Stimulus: feed 1,1,0,0 with en=0 cycles inserted between bits.
  - Response: match after the 4th enabled bit.
  - op stays high through subsequent en=0 cycles and drops on the next enabled edge.
  - Bits presented with en=0 are ignored.
- PATTERN=4'b0000, stream of 0s right after reset:
  - No hit on the first 3 bits; op after the 4th bit.
  - overlap=1: op remains high every cycle thereafter, and match_cnt increments every cycle.
- Counter behaviour, COUNT_W=2, overlap=1, PATTERN=4'b0000, zeros streamed:
  - match_cnt goes 1,2,3,3,3 (saturates).
  - Assert clr on a hit edge: match_cnt=0 on the next cycle, and op is still 1.
- Reset mid-operation, PATTERN=4'b1100:
  - Stimulus: feed 1,1,0, assert reset for 1 edge, then feed 0.
  - Response: no match; fill=1, op=0, match_cnt=0.
